// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage to multiply/divide unit bundle: operands, HI/LO moves, status and results.
interface muldiv_unit_if #(parameter int WIDTH = 32) ();
    import muldiv_unit_pkg::*;

    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit with architectural HI/LO registers.
// One accumulator {rem/prodhi, quot/prodlo} and one WIDTH+1-bit adder serve
// both shift-add multiply and restoring shift-subtract divide on magnitudes;
// a final FIX cycle applies the result signs and writes HI/LO.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    muldiv_state_t      state_q, state_d;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor magnitude
    logic               div_q;
    logic               negq_q;     // negate product / quotient
    logic               negr_q;     // negate remainder
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               in_div, in_sgn, in_dz, in_sa, in_sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_x, add_y, add_s;
    logic               add_c;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // Decode the incoming op and form operand magnitudes; divide-by-zero keeps raw a and drops signs.
    always_comb begin
        in_div = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
        in_sgn = (bus.op == MD_MULT) || (bus.op == MD_DIV);
        in_dz  = in_div && (bus.b == '0);
        in_sa  = in_sgn && bus.a[WIDTH-1] && !in_dz;
        in_sb  = in_sgn && bus.b[WIDTH-1] && !in_dz;
        mag_a  = in_sa ? ('0 - bus.a) : bus.a;
        mag_b  = in_sb ? ('0 - bus.b) : bus.b;
    end

    // Shared adder: conditional add of multiplicand, or trial subtract of divisor.
    always_comb begin
        if (div_q) begin
            add_x = acc_q[2*WIDTH-1:WIDTH-1];
            add_y = ~{1'b0, opb_q};
            add_c = 1'b1;
        end else begin
            add_x = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            add_y = acc_q[0] ? {1'b0, opb_q} : '0;
            add_c = 1'b0;
        end
        add_s = add_x + add_y + {{WIDTH{1'b0}}, add_c};

        if (div_q) begin
            // Bit WIDTH of the difference is the borrow: set means restore the shifted remainder.
            if (!add_s[WIDTH])
                acc_step = {add_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_step = {add_x[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {add_s, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod_neg = '0 - acc_q;
        if (div_q) begin
            fix_lo = negq_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            fix_hi = negr_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        end else begin
            fix_lo = negq_q ? prod_neg[WIDTH-1:0]       : acc_q[WIDTH-1:0];
            fix_hi = negq_q ? prod_neg[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic: IDLE -start-> CALC -count==0-> FIX -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (count_q == '0) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, HI/LO writes and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == FIX);
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        count_q <= LAST;
                        div_q   <= in_div;
                        negq_q  <= in_sa ^ in_sb;
                        negr_q  <= in_sa;
                        if (in_div) begin
                            acc_q <= {{WIDTH{1'b0}}, mag_a};
                            opb_q <= mag_b;
                        end else begin
                            acc_q <= {{WIDTH{1'b0}}, mag_b};
                            opb_q <= mag_a;
                        end
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    if (count_q != '0) count_q <= count_q - 1'b1;
                end
                FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input muldiv_op_t o, input logic [31:0] ia, input logic [31:0] ib);
        bus.op    = o;
        bus.a     = ia;
        bus.b     = ib;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Called just after the start edge; counts busy cycles and checks HI/LO hold mid-run.
    task automatic wait_done(input string tag, output int busy_cyc);
        int          guard;
        logic [31:0] hold_hi, hold_lo;
        hold_hi  = bus.hi;
        hold_lo  = bus.lo;
        busy_cyc = 0;
        guard    = 0;
        while (bus.done !== 1'b1 && guard < 200) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (guard == 16) begin
                check({tag, " hold hi"}, 64'(bus.hi), 64'(hold_hi));
                check({tag, " hold lo"}, 64'(bus.lo), 64'(hold_lo));
            end
            tick();
            guard++;
        end
        check({tag, " done seen"}, 64'(bus.done), 64'd1);
    endtask

    task automatic do_op(input string tag, input muldiv_op_t o, input logic [31:0] ia,
                         input logic [31:0] ib, input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        launch(o, ia, ib);
        wait_done(tag, cyc);
        check({tag, " hi"}, 64'(bus.hi), 64'(ehi));
        check({tag, " lo"}, 64'(bus.lo), 64'(elo));
        check({tag, " busy cycles"}, 64'(cyc), 64'd33);
        tick();
        check({tag, " done pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.start = 1'b0;
        bus.op    = MD_MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        rst       = 1'b1;
        tick();
        tick();
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hi",   64'(bus.hi),   64'd0);
        check("reset lo",   64'(bus.lo),   64'd0);
        rst = 1'b0;
        tick();

        // MTHI+MTLO together, then MTHI alone
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hDEADBEEF;
        tick();
        bus.mthi = 1'b1; bus.mtlo = 1'b0; bus.wdata = 32'h11111111;
        tick();
        bus.mthi = 1'b0;
        check("mthi hi", 64'(bus.hi), 64'h11111111);
        check("mtlo lo", 64'(bus.lo), 64'hDEADBEEF);

        do_op("multu max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        do_op("mult -3*5", MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        do_op("div -7/2",  MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu 7/2",  MD_DIVU,  32'd7,        32'd2,        32'd1,        32'd3);
        do_op("div 7/-2",  MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        do_op("div ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
        do_op("divu /0",   MD_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF);
        do_op("div -9/0",  MD_DIV,   32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF);

        // MTHI while busy is ignored
        launch(MD_DIVU, 32'd100, 32'd7);
        tick();
        bus.mthi = 1'b1; bus.wdata = 32'h000000A5;
        tick();
        bus.mthi = 1'b0;
        wait_done("mthi busy", cyc);
        check("mthi busy hi", 64'(bus.hi), 64'd2);
        check("mthi busy lo", 64'(bus.lo), 64'd14);
        tick();

        // MTHI in the same IDLE cycle as start is dropped
        bus.mthi = 1'b1; bus.wdata = 32'h000000A5;
        launch(MD_MULTU, 32'd2, 32'd3);
        bus.mthi = 1'b0;
        wait_done("mthi+start", cyc);
        check("mthi+start hi", 64'(bus.hi), 64'd0);
        check("mthi+start lo", 64'(bus.lo), 64'd6);

        // Back-to-back: new start accepted in the cycle done is high
        launch(MD_MULTU, 32'd5, 32'd6);
        check("b2b busy", 64'(bus.busy), 64'd1);
        check("b2b done low", 64'(bus.done), 64'd0);
        wait_done("b2b", cyc);
        check("b2b lo", 64'(bus.lo), 64'd30);
        check("b2b busy cycles", 64'(cyc), 64'd33);
        tick();

        // Asynchronous reset in the middle of an operation
        launch(MD_MULT, 32'd1000, 32'd1000);
        repeat (9) tick();
        check("pre-rst busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("async rst busy", 64'(bus.busy), 64'd0);
        check("async rst hi",   64'(bus.hi),   64'd0);
        check("async rst lo",   64'(bus.lo),   64'd0);
        tick();
        rst = 1'b0;
        tick();
        do_op("post-rst mult", MD_MULT, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'd0, 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
